// File: rtl/bean_fetch_pkg.sv
// Shared types and constants for the BEAN fetch sequencer.
// Build option: BEAN_FETCH_SKID_EN selects a 2-entry output buffer; otherwise 1 entry.
package bean_fetch_pkg;

   localparam int XPR_LEN  = 32;
   localparam int INST_LEN = 32;
   localparam logic [XPR_LEN-1:0] RESET_PC = 32'h0000_0200;
   localparam int PC_STEP  = 4;

`ifdef BEAN_FETCH_SKID_EN
   localparam int OBUF_DEPTH = 2;
`else
   localparam int OBUF_DEPTH = 1;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [XPR_LEN-1:0]  pc;
      logic [INST_LEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/bean_fetch_if.sv
// Fetch-side bundle: control inputs, imem request/response channel, decode channel.
// master = fetch controller, slave = surrounding core/memory.
interface bean_fetch_if #(
   parameter int XPR_LEN  = bean_fetch_pkg::XPR_LEN,
   parameter int INST_LEN = bean_fetch_pkg::INST_LEN
);

   logic                en;
   logic                redirect_valid;
   logic [XPR_LEN-1:0]  redirect_pc;

   logic                imem_req_valid;
   logic                imem_req_ready;
   logic [XPR_LEN-1:0]  imem_req_addr;
   logic                imem_resp_valid;
   logic [INST_LEN-1:0] imem_resp_data;

   logic                dec_valid;
   logic                dec_ready;
   logic [XPR_LEN-1:0]  dec_pc;
   logic [INST_LEN-1:0] dec_inst;

   logic                busy;

   modport master (
      input  en, redirect_valid, redirect_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  dec_ready,
      output imem_req_valid, imem_req_addr,
      output dec_valid, dec_pc, dec_inst,
      output busy
   );

   modport slave (
      output en, redirect_valid, redirect_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output dec_ready,
      input  imem_req_valid, imem_req_addr,
      input  dec_valid, dec_pc, dec_inst,
      input  busy
   );

endinterface

// File: rtl/bean_fetch_obuf.sv
// Output buffer between fetch and decode: in-order, head presented on entry_o.
// Depth is OBUF_DEPTH from the package (1, or 2 with BEAN_FETCH_SKID_EN).
// flush wins over push/pop; storage is only cleared by rst.
module bean_fetch_obuf
   import bean_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t entry_i,
   output logic         full,
   output logic         almost_full,
   output logic         empty,
   output fetch_entry_t entry_o
);

   localparam logic [1:0] DEPTH = 2'(OBUF_DEPTH);

   fetch_entry_t slot_q [OBUF_DEPTH];
   fetch_entry_t slot_d [OBUF_DEPTH];
   logic [1:0]   count_q, count_d;
   logic [1:0]   wr_idx;
   logic         push_en, pop_en;

   assign full        = (count_q == DEPTH);
   assign almost_full = (count_q >= (DEPTH - 2'd1));
   assign empty       = (count_q == 2'd0);
   assign entry_o     = slot_q[0];

   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);
   assign wr_idx  = count_q - {1'b0, pop_en};

   // Shift out the head on pop, then write the new entry behind whatever remains.
   always_comb begin
      slot_d  = slot_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         if (pop_en) begin
            for (int i = 0; i < OBUF_DEPTH - 1; i++) begin
               slot_d[i] = slot_q[i + 1];
            end
         end
         if (push_en) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
               if (wr_idx == 2'(i)) begin
                  slot_d[i] = entry_i;
               end
            end
         end
         count_d = count_q + {1'b0, push_en} - {1'b0, pop_en};
      end
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'd0;
         for (int i = 0; i < OBUF_DEPTH; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         slot_q  <= slot_d;
      end
   end

endmodule

// File: rtl/bean_fetch_ctrl.sv
// Fetch sequencer for the BEAN core: owns the PC, issues one imem read at a time,
// buffers returned words for decode and discards responses made stale by redirects.
// Build option: BEAN_FETCH_SKID_EN (via the package) deepens the output buffer to 2.
//
// state | meaning
// IDLE  | no request outstanding, waiting for en and a free buffer slot
// REQ   | request presented on imem, address held until accepted
// WAIT  | request accepted, response will be stored
// DROP  | request accepted before a redirect, response will be discarded
module bean_fetch_ctrl #(
   parameter int XPR_LEN  = bean_fetch_pkg::XPR_LEN,
   parameter int INST_LEN = bean_fetch_pkg::INST_LEN,
   parameter logic [XPR_LEN-1:0] RESET_PC = bean_fetch_pkg::RESET_PC
) (
   input  logic         clk,
   input  logic         rst,
   bean_fetch_if.master fif
);

   import bean_fetch_pkg::*;

   fetch_state_t       state_q, state_d;
   logic [XPR_LEN-1:0] pc_q, pc_d;
   logic [XPR_LEN-1:0] req_pc_q, req_pc_d;
   logic [XPR_LEN-1:0] redirect_pc_al;

   logic               req_hs;
   logic               dec_pop;
   logic               obuf_push;
   logic               obuf_full, obuf_afull, obuf_empty;
   logic               slot_free_idle, slot_free_wait;
   fetch_entry_t       obuf_in, obuf_out;

   assign req_hs         = (state_q == REQ) && fif.imem_req_ready;
   assign dec_pop        = !obuf_empty && fif.dec_ready;
   assign redirect_pc_al = {fif.redirect_pc[XPR_LEN-1:2], 2'b00};

   // A new request must have somewhere to land: from IDLE nothing is owed, from WAIT
   // the arriving response takes a slot first. A same-cycle pop frees one.
   assign slot_free_idle = !obuf_full || dec_pop;
   assign slot_free_wait = !obuf_afull || dec_pop;

   assign obuf_push    = (state_q == WAIT) && fif.imem_resp_valid && !fif.redirect_valid;
   assign obuf_in.pc   = req_pc_q;
   assign obuf_in.inst = fif.imem_resp_data;

   bean_fetch_obuf u_obuf (
      .clk         (clk),
      .rst         (rst),
      .push        (obuf_push),
      .pop         (dec_pop),
      .flush       (fif.redirect_valid),
      .entry_i     (obuf_in),
      .full        (obuf_full),
      .almost_full (obuf_afull),
      .empty       (obuf_empty),
      .entry_o     (obuf_out)
   );

   // State, PC and the PC of the in-flight request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   // Next state; redirect takes priority, but an accepted request is always followed
   // to its response (DROP) so there is never more than one outstanding.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (fif.en && (fif.redirect_valid || slot_free_idle)) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (fif.redirect_valid) begin
               state_d = req_hs ? DROP : REQ;
            end else if (req_hs) begin
               state_d = WAIT;
            end else if (!fif.en) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (fif.imem_resp_valid) begin
               if (fif.redirect_valid) begin
                  state_d = fif.en ? REQ : IDLE;
               end else begin
                  state_d = (fif.en && slot_free_wait) ? REQ : IDLE;
               end
            end else if (fif.redirect_valid) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (fif.imem_resp_valid) begin
               state_d = fif.en ? REQ : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // PC advances on acceptance and wraps silently; a redirect overrides it.
   always_comb begin
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      if (req_hs) begin
         req_pc_d = pc_q;
      end
      if (fif.redirect_valid) begin
         pc_d = redirect_pc_al;
      end else if (req_hs) begin
         pc_d = pc_q + XPR_LEN'(PC_STEP);
      end
   end

   // Outputs are decoded from registered state only.
   always_comb begin
      fif.imem_req_valid = (state_q == REQ);
      fif.imem_req_addr  = pc_q;
      fif.dec_valid      = !obuf_empty;
      fif.dec_pc         = obuf_out.pc;
      fif.dec_inst       = obuf_out.inst;
      fif.busy           = (state_q != IDLE);
   end

endmodule
